// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 6-stage RV32E pipeline: load-use scoreboard, EX redirects, memory-wait freeze.
// Define HAZARD_PERF_EN to add saturating stall/flush/memory-wait performance counters.
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_ID,
  input  logic [3:0] rs1_ID,
  input  logic [3:0] rs2_ID,
  input  logic       rs1_used_ID,
  input  logic       rs2_used_ID,
  input  logic       is_load_ID,
  input  logic [3:0] rd_ID,
  input  logic       redirect_EX,
  input  logic       mem_req_MEMPREP,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       hold_IF_ID,
  output logic       flush_IF_ID,
  output logic       bubble_ID_EX,
  output logic       freeze,
  output logic       mem_error
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] mem_wait_cycles
`endif
);

  if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_params
    $error("pipeline_hazard_controller: MEM_TIMEOUT must be 2..255 and CNT_W >= 1");
  end

  typedef struct packed {
    logic       v;
    logic [3:0] rd;
  } sb_entry_t;

  typedef enum logic {S_IDLE, S_WAIT} mem_state_e;

  localparam logic [7:0] WCNT_LAST = 8'(MEM_TIMEOUT - 1);

  mem_state_e state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       mem_error_q;
  logic       timeout;
  logic       freeze_mem;
  sb_entry_t  sb0_q, sb0_d, sb1_q, sb1_d;
  logic       load_use;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      mem_error_q <= 1'b0;
      sb0_q       <= '0;
      sb1_q       <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_error_q <= timeout;
      sb0_q       <= sb0_d;
      sb1_q       <= sb1_d;
    end
  end

  // The cycle after a timeout is the forced release, so a still-pending request is let through once.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves a latch behind.
    state_d = state_q;
    wcnt_d  = wcnt_q;
    timeout = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_req_MEMPREP && !mem_ready && !mem_error_q) begin
          state_d = S_WAIT;
          wcnt_d  = 8'd1;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
          timeout = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    freeze_mem = 1'b0;
    unique case (state_q)
      S_IDLE:  freeze_mem = mem_req_MEMPREP && !mem_ready && !mem_error_q;
      S_WAIT:  freeze_mem = !mem_ready;
      default: freeze_mem = 1'b0;
    endcase
  end

  assign load_use = valid_ID &&
                    ((rs1_used_ID && ((sb0_q.v && rs1_ID == sb0_q.rd) ||
                                      (sb1_q.v && rs1_ID == sb1_q.rd))) ||
                     (rs2_used_ID && ((sb0_q.v && rs2_ID == sb0_q.rd) ||
                                      (sb1_q.v && rs2_ID == sb1_q.rd))));

  always_comb begin
    pc_we        = 1'b1;
    hold_IF_ID   = 1'b0;
    flush_IF_ID  = 1'b0;
    bubble_ID_EX = 1'b0;
    freeze       = 1'b0;
    if (rst) begin
      pc_we        = 1'b0;
      flush_IF_ID  = 1'b1;
      bubble_ID_EX = 1'b1;
    end else if (freeze_mem) begin
      pc_we  = 1'b0;
      freeze = 1'b1;
    end else if (redirect_EX) begin
      flush_IF_ID  = 1'b1;
      bubble_ID_EX = 1'b1;
    end else if (load_use) begin
      pc_we        = 1'b0;
      hold_IF_ID   = 1'b1;
      bubble_ID_EX = 1'b1;
    end
  end

  // Scoreboard follows the load into EX and MEMPREP; a bubbled or killed ID instruction never enters.
  always_comb begin
    sb0_d = sb0_q;
    sb1_d = sb1_q;
    if (!freeze_mem) begin
      sb1_d    = sb0_q;
      sb0_d.v  = valid_ID && is_load_ID && (rd_ID != 4'd0) && !bubble_ID_EX;
      sb0_d.rd = rd_ID;
    end
  end

  assign mem_error = mem_error_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q, wait_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      if (load_use && !freeze_mem && !redirect_EX && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (redirect_EX && !freeze_mem && flush_q != '1) flush_q <= flush_q + 1'b1;
      if (freeze_mem && wait_q != '1) wait_q <= wait_q + 1'b1;
    end
  end

  assign stall_cycles    = stall_q;
  assign flush_count     = flush_q;
  assign mem_wait_cycles = wait_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MEM_TIMEOUT=4); checks counters when HAZARD_PERF_EN is defined.
module tb_pipeline_hazard_controller;

  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [3:0] rs1;
    logic       u1;
    logic [3:0] rs2;
    logic       u2;
    logic       ld;
    logic [3:0] rd;
    logic       redir;
    logic       req;
    logic       ready;
  } stim_t;

  // Observed vector: {pc_we, hold, flush, bubble, freeze, mem_error}
  localparam logic [5:0] RUN   = 6'b100000;
  localparam logic [5:0] STALL = 6'b010100;
  localparam logic [5:0] REDIR = 6'b101100;
  localparam logic [5:0] FRZ   = 6'b000010;
  localparam logic [5:0] RSTV  = 6'b001100;
  localparam logic [5:0] RELE  = 6'b100001;

  logic clk = 1'b0;
  logic rst, valid_ID, rs1_used_ID, rs2_used_ID, is_load_ID, redirect_EX, mem_req_MEMPREP, mem_ready;
  logic [3:0] rs1_ID, rs2_ID, rd_ID;
  logic pc_we, hold_IF_ID, flush_IF_ID, bubble_ID_EX, freeze, mem_error;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles, flush_count, mem_wait_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  wire [5:0] obs = {pc_we, hold_IF_ID, flush_IF_ID, bubble_ID_EX, freeze, mem_error};

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_ID(valid_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID), .is_load_ID(is_load_ID),
    .rd_ID(rd_ID), .redirect_EX(redirect_EX), .mem_req_MEMPREP(mem_req_MEMPREP),
    .mem_ready(mem_ready), .pc_we(pc_we), .hold_IF_ID(hold_IF_ID), .flush_IF_ID(flush_IF_ID),
    .bubble_ID_EX(bubble_ID_EX), .freeze(freeze), .mem_error(mem_error)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_wait_cycles(mem_wait_cycles)
`endif
  );

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t ldi(input logic [3:0] rd);
    stim_t s;
    s = '0;
    s.valid = 1'b1;
    s.ld    = 1'b1;
    s.rd    = rd;
    return s;
  endfunction

  function automatic stim_t alu(input logic [3:0] a, input logic ua, input logic [3:0] b, input logic ub);
    stim_t s;
    s = '0;
    s.valid = 1'b1;
    s.rs1 = a;
    s.u1  = ua;
    s.rs2 = b;
    s.u2  = ub;
    s.rd  = 4'd1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst             = s.rst;
    valid_ID        = s.valid;
    rs1_ID          = s.rs1;
    rs1_used_ID     = s.u1;
    rs2_ID          = s.rs2;
    rs2_used_ID     = s.u2;
    is_load_ID      = s.ld;
    rd_ID           = s.rd;
    redirect_EX     = s.redir;
    mem_req_MEMPREP = s.req;
    mem_ready       = s.ready;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t s;
    s = nop();
    s.rst = 1'b1;
    drive(s);
    next_cycle();
    s.req = 1'b1;
    s.redir = 1'b1;
    drive(s);
    #4;
    n_cmp++;
    if (obs !== RSTV) begin
      n_bad++;
      $display("FAIL reset_outputs: obs=%b exp=%b", obs, RSTV);
    end
    next_cycle();
    drive(nop());
    #4;
    n_cmp++;
    if (obs !== RUN) begin
      n_bad++;
      $display("FAIL after_reset: obs=%b exp=%b", obs, RUN);
    end
    next_cycle();
  endtask

  task automatic test_load_use_two();
    stim_t s[6];
    logic [5:0] e[6];
    s[0] = ldi(4'd5);                     e[0] = RUN;
    s[1] = alu(4'd5, 1'b1, 4'd2, 1'b1);   e[1] = STALL;
    s[2] = alu(4'd5, 1'b1, 4'd2, 1'b1);   e[2] = STALL;
    s[3] = alu(4'd5, 1'b1, 4'd2, 1'b1);   e[3] = RUN;
    s[4] = nop();                         e[4] = RUN;
    s[5] = nop();                         e[5] = RUN;
    for (int i = 0; i < 6; i++) begin
      drive(s[i]);
      #4;
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL load_use_two[%0d]: obs=%b exp=%b", i, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_load_use_one();
    stim_t s[14];
    logic [5:0] e[14];
    s[0]  = ldi(4'd5);                    e[0]  = RUN;
    s[1]  = alu(4'd3, 1'b1, 4'd4, 1'b1);  e[1]  = RUN;
    s[2]  = alu(4'd0, 1'b0, 4'd5, 1'b1);  e[2]  = STALL;
    s[3]  = alu(4'd0, 1'b0, 4'd5, 1'b1);  e[3]  = RUN;
    s[4]  = ldi(4'd0);                    e[4]  = RUN;
    s[5]  = alu(4'd0, 1'b1, 4'd0, 1'b1);  e[5]  = RUN;
    s[6]  = ldi(4'd9);                    e[6]  = RUN;
    s[7]  = alu(4'd9, 1'b0, 4'd9, 1'b0);  e[7]  = RUN;
    s[8]  = nop();                        e[8]  = RUN;
    s[9]  = ldi(4'd7);                    e[9]  = RUN;
    s[10] = alu(4'd7, 1'b1, 4'd7, 1'b1);  e[10] = RUN;
    s[10].valid = 1'b0;
    s[11] = alu(4'd7, 1'b1, 4'd0, 1'b0);  e[11] = STALL;
    s[12] = nop();                        e[12] = RUN;
    s[13] = nop();                        e[13] = RUN;
    for (int i = 0; i < 14; i++) begin
      drive(s[i]);
      #4;
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL load_use_one[%0d]: obs=%b exp=%b", i, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect();
    stim_t s[5];
    logic [5:0] e[5];
    s[0] = ldi(4'd5);                     e[0] = RUN;
    s[1] = alu(4'd5, 1'b1, 4'd0, 1'b0);   e[1] = REDIR;
    s[1].redir = 1'b1;
    s[2] = alu(4'd2, 1'b1, 4'd3, 1'b1);   e[2] = RUN;
    s[3] = nop();                         e[3] = RUN;
    s[4] = nop();                         e[4] = RUN;
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      #4;
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL redirect[%0d]: obs=%b exp=%b", i, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_mem_wait();
    stim_t s[9];
    logic [5:0] e[9];
    s[0] = ldi(4'd5);                     e[0] = RUN;
    for (int i = 1; i < 7; i++) s[i] = alu(4'd5, 1'b1, 4'd0, 1'b0);
    for (int i = 1; i < 5; i++) s[i].req = 1'b1;
    s[4].ready = 1'b1;
    e[1] = FRZ; e[2] = FRZ; e[3] = FRZ;
    e[4] = STALL; e[5] = STALL; e[6] = RUN;
    s[7] = nop();                         e[7] = RUN;
    s[8] = nop();                         e[8] = RUN;
    for (int i = 0; i < 9; i++) begin
      drive(s[i]);
      #4;
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL mem_wait[%0d]: obs=%b exp=%b", i, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect_freeze();
    stim_t s[3];
    logic [5:0] e[3];
    s[0] = nop(); s[0].redir = 1'b1; s[0].req = 1'b1;                     e[0] = FRZ;
    s[1] = nop(); s[1].redir = 1'b1; s[1].req = 1'b1; s[1].ready = 1'b1;  e[1] = REDIR;
    s[2] = nop();                                                         e[2] = RUN;
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      #4;
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL redirect_freeze[%0d]: obs=%b exp=%b", i, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    stim_t s[7];
    logic [5:0] e[7];
    for (int i = 0; i < 5; i++) begin
      s[i] = nop();
      s[i].req = 1'b1;
    end
    e[0] = FRZ; e[1] = FRZ; e[2] = FRZ; e[3] = FRZ; e[4] = RELE;
    s[5] = nop();                         e[5] = RUN;
    s[6] = nop();                         e[6] = RUN;
    for (int i = 0; i < 7; i++) begin
      drive(s[i]);
      #4;
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL timeout[%0d]: obs=%b exp=%b", i, obs, e[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_wait();
    stim_t s[4];
    logic [5:0] e[4];
    s[0] = nop(); s[0].req = 1'b1;                   e[0] = FRZ;
    s[1] = nop(); s[1].req = 1'b1;                   e[1] = FRZ;
    s[2] = nop(); s[2].req = 1'b1; s[2].rst = 1'b1;  e[2] = RSTV;
    s[3] = nop();                                    e[3] = RUN;
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      #4;
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL reset_mid_wait[%0d]: obs=%b exp=%b", i, obs, e[i]);
      end
      next_cycle();
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf_counters();
    stim_t s[10];
    s[0] = nop(); s[0].rst = 1'b1;
    s[1] = ldi(4'd5);
    s[2] = alu(4'd5, 1'b1, 4'd0, 1'b0);
    s[3] = alu(4'd5, 1'b1, 4'd0, 1'b0);
    s[4] = alu(4'd5, 1'b1, 4'd0, 1'b0);
    s[5] = nop(); s[5].redir = 1'b1;
    for (int i = 6; i < 10; i++) begin
      s[i] = nop();
      s[i].req = 1'b1;
    end
    s[9].ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(s[i]);
      next_cycle();
    end
    drive(nop());
    n_cmp++;
    if (stall_cycles !== 32'd2) begin
      n_bad++;
      $display("FAIL perf_stall: obs=%0d exp=2", stall_cycles);
    end
    n_cmp++;
    if (flush_count !== 32'd1) begin
      n_bad++;
      $display("FAIL perf_flush: obs=%0d exp=1", flush_count);
    end
    n_cmp++;
    if (mem_wait_cycles !== 32'd3) begin
      n_bad++;
      $display("FAIL perf_wait: obs=%0d exp=3", mem_wait_cycles);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(nop());
    test_reset();
    test_load_use_two();
    test_load_use_one();
    test_redirect();
    test_mem_wait();
    test_redirect_freeze();
    test_timeout();
    test_reset_mid_wait();
    test_timeout();
`ifdef HAZARD_PERF_EN
    test_perf_counters();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
